// File: rtl/conv_2d_seq_ctrl.sv
// conv_2d_seq_ctrl: sequencer for a single-MAC 2D valid convolution.
// Walks output pixels in raster order and reads the 25 input/kernel element pairs of each pixel.
// Both RAMs are read with one cycle of latency. The MAC runs one cycle behind the address stream.
// The saturated result is presented on a valid/ready port.
// Optional feature: define CONV_RELU_EN to clamp negative results to zero (ReLU).
module conv_2d_seq_ctrl #(
    parameter int IN_DIM = 28,
    parameter int K_DIM  = 5,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     abort_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [ADDR_W-1:0]        in_addr_o,
    input  logic signed [DATA_W-1:0] in_rdata_i,
    output logic [4:0]               k_addr_o,
    input  logic signed [DATA_W-1:0] k_rdata_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [OUT_W-1:0]  out_data_o,
    output logic [4:0]               out_row_o,
    output logic [4:0]               out_col_o
);

    localparam int OUT_DIM = IN_DIM - K_DIM + 1;
    localparam int KC_W    = (K_DIM > 1) ? $clog2(K_DIM) : 1;
    localparam int IDX_W   = 5;

    localparam logic [KC_W-1:0]  K_LAST   = KC_W'(K_DIM - 1);
    localparam logic [IDX_W-1:0] PIX_LAST = IDX_W'(OUT_DIM - 1);

    // Saturation bounds expressed at accumulator width; the minimum is the bitwise complement of the maximum.
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_FIN
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          row_q, row_d;
    logic [IDX_W-1:0]          col_q, col_d;
    logic [KC_W-1:0]           kr_q, kr_d;
    logic [KC_W-1:0]           kc_q, kc_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    // High in the cycle where RAM data returned for a read issued in RUN is on the bus.
    logic                      rd_vld_q, rd_vld_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic [ADDR_W-1:0]          in_row;
    logic [ADDR_W-1:0]          in_col;
    logic signed [OUT_W-1:0]    sat_val;

    assign prod     = in_rdata_i * k_rdata_i;
    assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

    assign in_row    = ADDR_W'(row_q) + ADDR_W'(kr_q);
    assign in_col    = ADDR_W'(col_q) + ADDR_W'(kc_q);
    assign in_addr_o = in_row * ADDR_W'(IN_DIM) + in_col;
    assign k_addr_o  = 5'(kr_q) * 5'(K_DIM) + 5'(kc_q);

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_FIN);
    assign out_valid_o = (state_q == S_OUT);
    assign out_row_o   = row_q;
    assign out_col_o   = col_q;
    assign out_data_o  = sat_val;

    // State and counter registers; reset clears every bit of progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            kr_q     <= '0;
            kc_q     <= '0;
            acc_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            kr_q     <= kr_d;
            kc_q     <= kc_d;
            acc_q    <= acc_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // Next-state logic: kernel walk, MAC update, pixel advance and abort override.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        kr_d     = kr_q;
        kc_d     = kc_q;
        acc_d    = rd_vld_q ? (acc_q + prod_ext) : acc_q;
        rd_vld_d = (state_q == S_RUN) && !abort_i;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                    kr_d    = '0;
                    kc_d    = '0;
                    acc_d   = '0;
                end
            end
            S_RUN: begin
                if (kc_q == K_LAST) begin
                    kc_d = '0;
                    if (kr_q == K_LAST) begin
                        kr_d    = '0;
                        state_d = S_DRAIN;
                    end else begin
                        kr_d = kr_q + KC_W'(1);
                    end
                end else begin
                    kc_d = kc_q + KC_W'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready_i) begin
                    if (row_q == PIX_LAST && col_q == PIX_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        if (col_q == PIX_LAST) begin
                            col_d = '0;
                            row_d = row_q + IDX_W'(1);
                        end else begin
                            col_d = col_q + IDX_W'(1);
                        end
                        acc_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_i) begin
            state_d = S_IDLE;
            acc_d   = '0;
        end
    end

    // Saturate the accumulator to the output width, optionally followed by ReLU.
    always_comb begin
        if (acc_q > SAT_MAX) begin
            sat_val = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (acc_q < SAT_MIN) begin
            sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat_val = acc_q[OUT_W-1:0];
        end
`ifdef CONV_RELU_EN
        if (sat_val[OUT_W-1]) begin
            sat_val = '0;
        end
`else
`endif
    end

endmodule

// File: tb/tb_conv_2d_seq_ctrl.sv
// tb_conv_2d_seq_ctrl: self-checking bench for conv_2d_seq_ctrl.
// The RAMs are behavioural arrays with a one-cycle read. Expected pixels come from a direct
// convolution computed over those arrays.
// Honours CONV_RELU_EN in the same way as the design.
module tb_conv_2d_seq_ctrl;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [9:0]        in_addr;
    logic signed [7:0] in_rdata;
    logic [4:0]        k_addr;
    logic signed [7:0] k_rdata;
    logic              out_valid;
    logic              out_ready;
    logic signed [15:0] out_data;
    logic [4:0]        out_row;
    logic [4:0]        out_col;

    int checks = 0;
    int errors = 0;

    logic signed [7:0] in_mem [0:1023];
    logic signed [7:0] k_mem  [0:31];
    int                exp_q  [0:575];

    always #5 clk = ~clk;

    conv_2d_seq_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .busy_o      (busy),
        .done_o      (done),
        .in_addr_o   (in_addr),
        .in_rdata_i  (in_rdata),
        .k_addr_o    (k_addr),
        .k_rdata_i   (k_rdata),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_row_o   (out_row),
        .out_col_o   (out_col)
    );

    // One-cycle-latency RAM models.
    always @(posedge clk) begin
        in_rdata <= in_mem[in_addr];
        k_rdata  <= k_mem[k_addr];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int relu_ref(input int v);
`ifdef CONV_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int sat_ref(input longint s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return int'(s);
    endfunction

    // Direct 2D valid convolution over the RAM arrays.
    task automatic compute_expected();
        for (int i = 0; i < 24; i++) begin
            for (int j = 0; j < 24; j++) begin
                longint s = 0;
                for (int kr = 0; kr < 5; kr++)
                    for (int kc = 0; kc < 5; kc++)
                        s += longint'(in_mem[(i + kr) * 28 + j + kc]) * longint'(k_mem[kr * 5 + kc]);
                exp_q[i * 24 + j] = relu_ref(sat_ref(s));
            end
        end
    endtask

    task automatic fill_const(input logic signed [7:0] iv, input logic signed [7:0] kv);
        for (int a = 0; a < 1024; a++) in_mem[a] = iv;
        for (int a = 0; a < 32; a++)   k_mem[a]  = (a < 25) ? kv : 8'sd0;
    endtask

    // mode 0: ready held 1; mode 1: random ready; mode 2: 10-cycle stall at pixel (0,5).
    // max_pix < 576 aborts after that many handshakes. exp_done < 0 skips the done-cycle check.
    task automatic run_seq(input string tag, input int mode, input int max_pix, input bit poke,
                           input int exp_done);
        int cyc = 0;
        int n = 0;
        int first = -1;
        int done_cyc = -1;
        int stall = 0;
        bit stable = 1'b1;
        bit busy_ok = 1'b1;
        bit rdy;
        logic signed [15:0] s_data;
        logic [4:0] s_row, s_col, s_kaddr;
        logic [9:0] s_iaddr;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 20000) begin
            if (poke) start = (cyc == 500 || cyc == 9000 || cyc == 15552);
            if (!busy) busy_ok = 1'b0;
            rdy = 1'b1;
            if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            if (mode == 2 && out_valid && out_row == 5'd0 && out_col == 5'd5 && stall < 10) begin
                rdy = 1'b0;
                if (stall == 0) begin
                    s_data = out_data; s_row = out_row; s_col = out_col;
                    s_iaddr = in_addr; s_kaddr = k_addr;
                end else if (out_data !== s_data || out_row !== s_row || out_col !== s_col ||
                             in_addr !== s_iaddr || k_addr !== s_kaddr || !out_valid) begin
                    stable = 1'b0;
                end
                stall++;
            end
            out_ready = rdy;
            if (out_valid && first < 0) first = cyc;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (out_valid && rdy) begin
                chk({tag, " data"}, out_data, exp_q[n]);
                chk({tag, " row_col"}, {out_row, out_col}, {5'(n / 24), 5'(n % 24)});
                n++;
                if (max_pix < 576 && n == max_pix) break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk({tag, " first_valid_cycle"}, first, 27);
        if (max_pix < 576) begin
            @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk({tag, " abort_idle"}, {busy, out_valid, done}, 3'b000);
        end else begin
            chk({tag, " pixel_count"}, n, 576);
            chk({tag, " busy_during_run"}, busy_ok, 1);
            if (exp_done >= 0) chk({tag, " done_cycle"}, done_cyc, exp_done);
            else chk({tag, " done_seen"}, done_cyc > 0, 1);
            @(negedge clk);
            chk({tag, " done_pulse_busy_low"}, {done, busy}, 2'b00);
            if (mode == 2) begin
                chk({tag, " stall_len"}, stall, 10);
                chk({tag, " stall_stable"}, stable, 1);
            end
        end
        $display("run %s mode=%0d pixels=%0d first=%0d done=%0d", tag, mode, n, first, done_cyc);
    endtask

    typedef struct {
        logic signed [7:0] in_v;
        logic signed [7:0] k_v;
        int                exp_v;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int cyc;
        bit no_done;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        fill_const(8'sd0, 8'sd0);
        #1;
        chk("reset_ctrl", {busy, done, out_valid}, 3'b000);
        chk("reset_addr", {in_addr, k_addr}, 15'd0);
        chk("reset_out", {out_data, out_row, out_col}, 26'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Constant-fill vectors: every pixel is 25*in*k, saturated.
        vecs[0] = '{8'sd1,    8'sd1,    25};
        vecs[1] = '{8'sd127,  8'sd127,  32767};
        vecs[2] = '{8'sd127, -8'sd128, -32768};
        vecs[3] = '{-8'sd128, -8'sd128, 32767};
        vecs[4] = '{8'sd2,   -8'sd3,   -150};
        vecs[5] = '{8'sd10,   8'sd10,   2500};
        vecs[6] = '{-8'sd5,   8'sd7,   -875};
        for (int v = 0; v < 7; v++) begin
            fill_const(vecs[v].in_v, vecs[v].k_v);
            for (int p = 0; p < 576; p++) exp_q[p] = relu_ref(vecs[v].exp_v);
            run_seq($sformatf("vec%0d", v), 0, 3, 1'b0, -1);
        end

        // Abort at c+100, then a full all-ones run with starts poked while busy.
        fill_const(8'sd1, 8'sd1);
        compute_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_pre_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_next_cycle", {busy, out_valid}, 2'b00);
        no_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) no_done = 1'b0;
            @(negedge clk);
        end
        chk("abort_no_done", no_done, 1);
        $display("run abort at cycle 100");
        run_seq("ones", 0, 576, 1'b1, 15553);

        // Single-tap kernel: output equals the input shifted by (2,2); stall at (0,5).
        for (int a = 0; a < 1024; a++) in_mem[a] = 8'((a % 784) % 128);
        for (int a = 0; a < 32; a++) k_mem[a] = (a == 12) ? 8'sd1 : 8'sd0;
        compute_expected();
        chk("tap_model", exp_q[0], 58);
        run_seq("tap_stall", 2, 576, 1'b0, 15563);

        // Random data with random backpressure.
        for (int a = 0; a < 1024; a++) in_mem[a] = 8'($urandom);
        for (int a = 0; a < 32; a++) k_mem[a] = (a < 25) ? 8'($urandom) : 8'sd0;
        compute_expected();
        run_seq("random", 1, 576, 1'b0, -1);

        // Reset asserted in the middle of a run.
        fill_const(8'sd1, 8'sd1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        chk("midrun_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_ctrl", {busy, done, out_valid}, 3'b000);
        chk("midrun_reset_addr", {in_addr, k_addr}, 15'd0);
        chk("midrun_reset_out", {out_data, out_row, out_col}, 26'd0);
        $display("run reset mid-RUN");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
